tile_dmem_port: RTL and testbench
=================================

Name: tile_dmem_port

Overview:
- Shared data memory and arbiter serving the load/store instruction classes of up to NUM_TILES CGRA tiles.
- Class 001 is "send to data memory" (store); class 010 is "recv from data memory" (load).
- Sits directly downstream of each tile's execute stage; tiles present a 10-bit address (instruction bits [35:26]) plus 48-bit register data.
- Grants one request per cycle round-robin; returns load data one cycle after grant.

Parameters:
- NUM_TILES, 4, number of requesting tiles.
- DATA_W, 48, word width; matches the tile register width.
- ADDR_W, 10, request address width.
- DEPTH, 1024, implemented words; must be <= 2**ADDR_W.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_TILES  per-tile request pending.
- req_write  in  NUM_TILES  1 = store, 0 = load, per tile.
- req_addr  in  NUM_TILES*ADDR_W  tile t address at [t*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_TILES*DATA_W  tile t store data at [t*DATA_W +: DATA_W].
- req_ready  out  NUM_TILES  one-hot grant; request accepted when valid & ready.
- rsp_valid  out  NUM_TILES  one-cycle pulse to the tile whose load completes.
- rsp_rdata  out  DATA_W  load data, shared bus, qualified by rsp_valid.
- busy  out  1  high while no request can be accepted.
- err_oob  out  1  sticky: an out-of-range access occurred.

Behaviour:
- Reset (rst low, async): req_ready=0, rsp_valid=0, rsp_rdata=0, busy=0, err_oob=0, round-robin pointer ptr=0. Memory contents are not reset unless DMEM_CLEAR_EN is defined.
- Reset mid-operation: any in-flight load response is dropped; no rsp_valid after rst releases.
- Arbitration (combinational from req_valid and ptr):
  - Search order ptr, ptr+1, ... with wrap at NUM_TILES; the first valid tile is granted.
  - req_ready is one-hot on the granted tile; all zero if no requester is valid or busy=1.
  - A tile must hold valid/write/addr/wdata stable until ready.
- Pointer update: on a grant to tile g, ptr <= (g+1) mod NUM_TILES at the clock edge. No grant leaves ptr unchanged.
- Store: memory[addr] <= wdata at the grant edge; no response.
- Load:
  - Registered read. Grant at cycle N gives rsp_rdata = memory[addr] and rsp_valid[g]=1 during cycle N+1.
  - Back-to-back grants give back-to-back responses; throughput is 1 access/cycle.
- Ordering: a store granted at N followed by a load of the same address granted at N+1 or later returns the new data. Same-cycle conflict is impossible (single grant).
- Out of range (addr >= DEPTH):
  - Store is dropped.
  - Load returns 0 with a normal rsp_valid pulse.
  - err_oob is set and held until reset.
- rsp_rdata holds its last value when no response is issued.
- Fairness: with all tiles continuously requesting, grants rotate 0,1,2,3,0,...; worst-case wait is NUM_TILES-1 cycles.

Optional Feature:
- Macro DMEM_CLEAR_EN.
- Defined:
  - After rst deasserts, FSM CLEAR writes 0 to addresses 0..DEPTH-1, one per cycle, then enters RUN.
  - During CLEAR: busy=1, req_ready=0.
  - Duration is exactly DEPTH cycles.
  - Reset during CLEAR restarts the clear from address 0.
- Undefined:
  - FSM and clear counter are absent; busy is tied 0.
  - Requests are accepted in the first cycle after rst deasserts.
  - Memory contents survive reset.

Decomposition:
- Package tile_dmem_pkg:
  - DATA_W, ADDR_W.
  - Instruction class encodings OP_DMEM_STORE=3'b001, OP_DMEM_LOAD=3'b010.
  - Address field position constants ADDR_LSB=26, ADDR_MSB=35.
- Sub-module rr_arbiter:
  - Parameterised by NUM_TILES.
  - Inputs: request vector, enable.
  - Outputs: one-hot grant and binary index.
  - Owns the ptr register.

Test Plan:
- Basic store/load: tile0 stores 48'h0000_DEAD_BEEF at addr 10'h005, then tile0 loads 10'h005 → rsp_valid[0] one cycle after grant, rsp_rdata=48'h0000_DEAD_BEEF.
- Round-robin: all 4 tiles hold load requests for 8 cycles → grant sequence 0,1,2,3,0,1,2,3; each rsp_valid[t] arrives one cycle after its grant.
- Store-then-load back-to-back: tile2 stores 48'h1234 to 10'h3FF at cycle N; tile3 loads 10'h3FF granted at N+1 → rsp_rdata=48'h1234 at N+2.
- Out of range: with DEPTH=512, tile1 stores 48'h5 at 10'h200, then loads 10'h200 → rsp_rdata=0, err_oob=1 and held until reset.
- Reset mid-load: assert rst in the cycle after a load grant → no rsp_valid after release, ptr=0, err_oob=0.
- DMEM_CLEAR_EN with DEPTH=16: after reset, busy=1 and req_ready=0 for 16 cycles, then a load of 10'h007 returns 0.

Source files
------------

// File: rtl/tile_dmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tile_dmem_pkg
//  Description : Shared constants for the CGRA tile data-memory port.
//                Holds the word/address widths, the load/store instruction
//                class encodings, the position of the address field inside
//                a tile instruction, and the clear-FSM state encodings.
//  Revision    : 1.0  initial release
// ============================================================================
package tile_dmem_pkg;

    localparam int DATA_W   = 48;
    localparam int ADDR_W   = 10;

    // Instruction classes served by this port.
    typedef enum logic [2:0] {
        OP_DMEM_STORE = 3'b001,
        OP_DMEM_LOAD  = 3'b010
    } dmem_op_e;

    // Address field inside a tile instruction word.
    localparam int ADDR_LSB = 26;
    localparam int ADDR_MSB = 35;

    // Memory-clear FSM states (only used when DMEM_CLEAR_EN is defined).
    localparam logic [0:0] CLR_ST_CLEAR = 1'b0;
    localparam logic [0:0] CLR_ST_RUN   = 1'b1;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Single-grant round-robin arbiter. The search starts at the
//                pointer and wraps; after a grant to tile g the pointer moves
//                to g+1 so every requester waits at most NUM_TILES-1 cycles.
//  Ports       : clk, rst (async, active-low)
//                req      - request vector
//                en       - grant enable (0 forces an all-zero grant)
//                gnt      - one-hot grant
//                gnt_idx  - binary index of the granted requester
//                gnt_vld  - a grant is being issued this cycle
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter #(
    parameter  int NUM_TILES = 4,
    localparam int IDX_W     = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_TILES-1:0] req,
    input  logic                 en,
    output logic [NUM_TILES-1:0] gnt,
    output logic [IDX_W-1:0]     gnt_idx,
    output logic                 gnt_vld
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;

    always_comb begin
        int cand;
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        cand    = 0;
        // Walk the search order backwards so the last hit, which is the
        // closest to the pointer, is the one that sticks.
        for (int i = NUM_TILES - 1; i >= 0; i--) begin
            cand = (int'(ptr_q) + i) % NUM_TILES;
            if (en && req[cand]) begin
                gnt_idx = IDX_W'(cand);
                gnt_vld = 1'b1;
            end
        end
        if (gnt_vld) begin
            gnt[gnt_idx] = 1'b1;
        end

        ptr_d = ptr_q;
        if (gnt_vld) begin
            ptr_d = (int'(gnt_idx) == NUM_TILES - 1) ? '0 : gnt_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/tile_dmem_port.sv
`default_nettype none
// ============================================================================
//  Module      : tile_dmem_port
//  Description : Shared data memory for the load/store classes of up to
//                NUM_TILES CGRA tiles. One request is granted per cycle in
//                round-robin order; stores write at the grant edge, loads
//                return data on the shared bus one cycle after grant.
//                Accesses at addr >= DEPTH are dropped (store) or return 0
//                (load) and set the sticky err_oob flag.
//  Config      : DMEM_CLEAR_EN - when defined, the memory is zeroed one word
//                per cycle after every reset; busy is high meanwhile.
//  Ports       : clk, rst (async, active-low)
//                req_valid/req_write/req_addr/req_wdata - per-tile request
//                req_ready - one-hot grant
//                rsp_valid - per-tile load completion pulse
//                rsp_rdata - shared load data bus
//                busy      - no request can be accepted
//                err_oob   - sticky out-of-range flag
//  Revision    : 1.0  initial release
// ============================================================================
module tile_dmem_port #(
    parameter int NUM_TILES = 4,
    parameter int DATA_W    = 48,
    parameter int ADDR_W    = 10,
    parameter int DEPTH     = 1024
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_TILES-1:0]        req_valid,
    input  logic [NUM_TILES-1:0]        req_write,
    input  logic [NUM_TILES*ADDR_W-1:0] req_addr,
    input  logic [NUM_TILES*DATA_W-1:0] req_wdata,
    output logic [NUM_TILES-1:0]        req_ready,
    output logic [NUM_TILES-1:0]        rsp_valid,
    output logic [DATA_W-1:0]           rsp_rdata,
    output logic                        busy,
    output logic                        err_oob
);

    import tile_dmem_pkg::*;

    localparam int IDX_W  = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0]    mem [DEPTH];

    logic                 w_busy;
    logic                 w_arb_en;
    logic [NUM_TILES-1:0] w_gnt;
    logic [IDX_W-1:0]     w_gnt_idx;
    logic                 w_gnt_vld;
    logic                 w_sel_write;
    logic [ADDR_W-1:0]    w_sel_addr;
    logic [DATA_W-1:0]    w_sel_wdata;
    logic [MEM_AW-1:0]    w_mem_idx;
    logic                 w_oob;
    logic                 w_st;
    logic                 w_ld;
    logic                 w_mem_we;
    logic [MEM_AW-1:0]    w_mem_waddr;
    logic [DATA_W-1:0]    w_mem_wdata;

    logic [NUM_TILES-1:0] rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]    rsp_rdata_q, rsp_rdata_d;
    logic                 err_oob_q,   err_oob_d;

    // Grants are also blocked while rst is low so req_ready reads 0 in reset.
    assign w_arb_en = rst & ~w_busy;

    rr_arbiter #(
        .NUM_TILES (NUM_TILES)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req_valid),
        .en      (w_arb_en),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx),
        .gnt_vld (w_gnt_vld)
    );

    // Mux the granted tile's request onto a single access path.
    assign w_sel_write = req_write[w_gnt_idx];
    assign w_sel_addr  = req_addr[w_gnt_idx*ADDR_W +: ADDR_W];
    assign w_sel_wdata = req_wdata[w_gnt_idx*DATA_W +: DATA_W];
    assign w_oob       = int'(w_sel_addr) >= DEPTH;
    assign w_mem_idx   = w_sel_addr[MEM_AW-1:0];

    assign w_st = w_gnt_vld &  w_sel_write & ~w_oob;
    assign w_ld = w_gnt_vld & ~w_sel_write;

`ifdef DMEM_CLEAR_EN
    logic [0:0]        clr_state_q, clr_state_d;
    logic [MEM_AW-1:0] clr_addr_q,  clr_addr_d;
    logic              w_clr_active;

    assign w_clr_active = (clr_state_q == CLR_ST_CLEAR);
    // Held low during reset itself; rises on release for exactly DEPTH cycles.
    assign w_busy       = rst & w_clr_active;

    always_comb begin
        clr_state_d = clr_state_q;
        clr_addr_d  = clr_addr_q;
        if (w_clr_active) begin
            if (int'(clr_addr_q) == DEPTH - 1) begin
                clr_state_d = CLR_ST_RUN;
            end else begin
                clr_addr_d = clr_addr_q + MEM_AW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clr_state_q <= CLR_ST_CLEAR;
            clr_addr_q  <= '0;
        end else begin
            clr_state_q <= clr_state_d;
            clr_addr_q  <= clr_addr_d;
        end
    end

    // The clear owns the write port; no grants can occur while it runs.
    always_comb begin
        w_mem_we    = w_st;
        w_mem_waddr = w_mem_idx;
        w_mem_wdata = w_sel_wdata;
        if (w_clr_active) begin
            w_mem_we    = 1'b1;
            w_mem_waddr = clr_addr_q;
            w_mem_wdata = '0;
        end
    end
`else
    assign w_busy      = 1'b0;
    assign w_mem_we    = w_st;
    assign w_mem_waddr = w_mem_idx;
    assign w_mem_wdata = w_sel_wdata;
`endif

    // Storage has no reset; contents survive rst unless cleared above.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            mem[w_mem_waddr] <= w_mem_wdata;
        end
    end

    always_comb begin
        rsp_valid_d = w_ld ? w_gnt : '0;
        rsp_rdata_d = rsp_rdata_q;
        if (w_ld) begin
            rsp_rdata_d = w_oob ? '0 : mem[w_mem_idx];
        end
        err_oob_d = err_oob_q | (w_gnt_vld & w_oob);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            err_oob_q   <= 1'b0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            err_oob_q   <= err_oob_d;
        end
    end

    assign req_ready = w_gnt;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign busy      = w_busy;
    assign err_oob   = err_oob_q;

endmodule
`default_nettype wire

// File: tb/tb_tile_dmem_port.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tile_dmem_port
//  Description : Self-checking bench for tile_dmem_port. A negedge monitor
//                holds a reference model (round-robin pointer, memory,
//                sticky error, clear countdown) and a response scoreboard;
//                a vector table plus hand-written sequences drive stimulus.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_tile_dmem_port;

    localparam int NT = 4;
    localparam int DW = 48;
    localparam int AW = 10;
`ifdef DMEM_CLEAR_EN
    localparam int DEPTH = 16;
    localparam bit CLR   = 1'b1;
`else
    localparam int DEPTH = 512;
    localparam bit CLR   = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic [NT-1:0]  req_valid;
    logic [NT-1:0]  req_write;
    logic [NT*AW-1:0] req_addr;
    logic [NT*DW-1:0] req_wdata;
    logic [NT-1:0]  req_ready;
    logic [NT-1:0]  rsp_valid;
    logic [DW-1:0]  rsp_rdata;
    logic           busy;
    logic           err_oob;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    tile_dmem_port #(
        .NUM_TILES (NT),
        .DATA_W    (DW),
        .ADDR_W    (AW),
        .DEPTH     (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .busy      (busy),
        .err_oob   (err_oob)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model + scoreboard ----------------
    typedef struct {
        logic [NT-1:0] tile;
        logic [DW-1:0] data;
        bit            known;
    } rsp_t;

    rsp_t          sb_q[$];
    logic [DW-1:0] m_mem   [1024];
    bit            m_known [1024];
    int            m_ptr    = 0;
    bit            m_err    = 1'b0;
    int            clr_left = 0;

    always @(negedge clk) begin
        rsp_t          e;
        int            g;
        int            idx;
        int            a;
        logic [NT-1:0] exp_rdy;
        if (!rst) begin
            sb_q.delete();
            m_ptr = 0;
            m_err = 1'b0;
            if (CLR) begin
                clr_left = DEPTH;
                for (int i = 0; i < DEPTH; i++) begin
                    m_mem[i]   = '0;
                    m_known[i] = 1'b1;
                end
            end
            chk("rst_ready", req_ready, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_rsp_rdata", rsp_rdata, 0);
            chk("rst_busy", busy, 0);
            chk("rst_err_oob", err_oob, 0);
        end else begin
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("rsp_valid", rsp_valid, e.tile);
                if (e.known) chk("rsp_rdata", rsp_rdata, e.data);
            end else begin
                chk("rsp_idle", rsp_valid, 0);
            end
            chk("err_oob", err_oob, m_err);
            if (clr_left > 0) begin
                chk("clr_busy", busy, 1);
                chk("clr_ready", req_ready, 0);
                clr_left--;
            end else begin
                chk("busy", busy, 0);
                g = -1;
                for (int i = 0; i < NT; i++) begin
                    idx = (m_ptr + i) % NT;
                    if (g < 0 && req_valid[idx] === 1'b1) g = idx;
                end
                exp_rdy = '0;
                if (g >= 0) exp_rdy[g] = 1'b1;
                chk("grant", req_ready, exp_rdy);
                if (g >= 0) begin
                    a = int'(req_addr[g*AW +: AW]);
                    if (a >= DEPTH) m_err = 1'b1;
                    if (req_write[g]) begin
                        if (a < DEPTH) begin
                            m_mem[a]   = req_wdata[g*DW +: DW];
                            m_known[a] = 1'b1;
                        end
                    end else begin
                        e.tile  = exp_rdy;
                        e.data  = (a >= DEPTH) ? '0 : m_mem[a];
                        e.known = (a >= DEPTH) || m_known[a];
                        sb_q.push_back(e);
                    end
                    m_ptr = (g + 1) % NT;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
    endtask

    task automatic set_tile(input int t, input logic v, input logic w,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[t]         = v;
        req_write[t]         = w;
        req_addr[t*AW +: AW] = a;
        req_wdata[t*DW +: DW] = d;
    endtask

    task automatic do_reset();
        int n;
        rst = 1'b0;
        clear_reqs();
        step();
        step();
        rst = 1'b1;
        n = 0;
        while (busy === 1'b1 && n < 4 * DEPTH + 8) begin
            step();
            n++;
        end
        chk("clear_len", n, CLR ? DEPTH : 0);
    endtask

    typedef struct {
        logic [NT-1:0] valid;
        logic [NT-1:0] write;
        logic [NT-1:0] exp_ready;
    } vec_t;

    vec_t tbl[16];

    initial begin
        // Pointer starts at 0 after reset; expected grants derived by hand.
        tbl[0]  = '{4'b1111, 4'b1111, 4'b0001};
        tbl[1]  = '{4'b1111, 4'b1111, 4'b0010};
        tbl[2]  = '{4'b1111, 4'b1111, 4'b0100};
        tbl[3]  = '{4'b1111, 4'b1111, 4'b1000};
        tbl[4]  = '{4'b1111, 4'b0000, 4'b0001};
        tbl[5]  = '{4'b1111, 4'b0000, 4'b0010};
        tbl[6]  = '{4'b1111, 4'b0000, 4'b0100};
        tbl[7]  = '{4'b1111, 4'b0000, 4'b1000};
        tbl[8]  = '{4'b0000, 4'b0000, 4'b0000};
        tbl[9]  = '{4'b1010, 4'b0000, 4'b0010};
        tbl[10] = '{4'b1010, 4'b0000, 4'b1000};
        tbl[11] = '{4'b0001, 4'b0000, 4'b0001};
        tbl[12] = '{4'b1001, 4'b0000, 4'b1000};
        tbl[13] = '{4'b0110, 4'b0101, 4'b0010};
        tbl[14] = '{4'b0110, 4'b0101, 4'b0100};
        tbl[15] = '{4'b1111, 4'b0000, 4'b1000};

        rst = 1'b0;
        clear_reqs();
        do_reset();

        // Basic store then load on tile 0.
        set_tile(0, 1'b1, 1'b1, 10'h005, 48'h0000_DEAD_BEEF);
        step();
        set_tile(0, 1'b1, 1'b0, 10'h005, '0);
        step();
        clear_reqs();
        @(negedge clk);
        chk("basic_rsp_valid", rsp_valid, 4'b0001);
        chk("basic_rsp_rdata", rsp_rdata, 48'h0000_DEAD_BEEF);
        step();
        @(negedge clk);
        chk("basic_rdata_hold", rsp_rdata, 48'h0000_DEAD_BEEF);
        step();

        // Table-driven vectors starting from a known pointer.
        do_reset();
        for (int r = 0; r < 16; r++) begin
            for (int t = 0; t < NT; t++) begin
                set_tile(t, tbl[r].valid[t], tbl[r].write[t], AW'(10'h020 + t),
                         48'hA000_0000_0000 | (48'(r) << 8) | 48'(t));
            end
            @(negedge clk);
            chk("tbl_ready", req_ready, tbl[r].exp_ready);
            step();
        end
        clear_reqs();
        step();
        step();

        // Store at N, load of the same last word at N+1 from another tile.
        set_tile(2, 1'b1, 1'b1, AW'(DEPTH - 1), 48'h1234);
        step();
        set_tile(2, 1'b0, 1'b0, '0, '0);
        set_tile(3, 1'b1, 1'b0, AW'(DEPTH - 1), '0);
        step();
        clear_reqs();
        @(negedge clk);
        chk("st_ld_rsp_valid", rsp_valid, 4'b1000);
        chk("st_ld_rsp_rdata", rsp_rdata, 48'h1234);
        step();

        // Out-of-range store and load.
        set_tile(1, 1'b1, 1'b1, 10'h200, 48'h5);
        step();
        set_tile(1, 1'b1, 1'b0, 10'h200, '0);
        step();
        clear_reqs();
        @(negedge clk);
        chk("oob_rsp_valid", rsp_valid, 4'b0010);
        chk("oob_rsp_rdata", rsp_rdata, 0);
        chk("oob_err", err_oob, 1);
        repeat (3) step();
        @(negedge clk);
        chk("oob_err_held", err_oob, 1);
        step();

        // Reset in the cycle after a load grant.
        set_tile(0, 1'b1, 1'b0, 10'h005, '0);
        step();
        do_reset();
        repeat (3) step();
        @(negedge clk);
        chk("mid_rst_err", err_oob, 0);
        chk("mid_rst_rsp", rsp_valid, 0);
        step();
        for (int t = 0; t < NT; t++) set_tile(t, 1'b1, 1'b0, 10'h005, '0);
        @(negedge clk);
        chk("mid_rst_ptr0", req_ready, 4'b0001);
        step();
        clear_reqs();
        step();
        step();

`ifdef DMEM_CLEAR_EN
        // Memory was zeroed by the post-reset clear.
        set_tile(0, 1'b1, 1'b0, 10'h007, '0);
        step();
        clear_reqs();
        @(negedge clk);
        chk("clr_load_valid", rsp_valid, 4'b0001);
        chk("clr_load_rdata", rsp_rdata, 0);
        step();
`endif

        repeat (3) step();
        chk("sb_drain", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
